// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

   localparam int unsigned MDU_LAT_DEF = 32;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_BUSY = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_mdu_countdown.sv
// Down-counter holding the remaining execute cycles of an in-flight multi-cycle MDU op.
module mdu_countdown
   import pipe_ctrl_pkg::*;
#(
   parameter  int unsigned MDU_LAT = MDU_LAT_DEF,
   localparam int unsigned CW      = $clog2(MDU_LAT + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          i_load,
   input  logic          i_dec,
   input  logic          i_clear,
   output logic [CW-1:0] o_cnt,
   output logic          o_done
);

   logic [CW-1:0] r_cnt;

   // Launch cycle is the first of MDU_LAT, so the busy phase counts MDU_LAT-1 down to 1.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= CW'(MDU_LAT - 1);
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_done = i_dec && (r_cnt == CW'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage stall/flush from branch, exception, load-use,
// multi-cycle MDU and data-memory wait events.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MDU_LAT = MDU_LAT_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       io_in_brTaken,
   input  logic       io_in_excpValid,
   input  logic       io_in_loadUse,
   input  logic       io_in_mduStart,
   input  logic       io_in_dmemReqValid,
   input  logic       io_in_dmemRespValid,
   output logic       io_out_fetch_stall,
   output logic       io_out_decode_stall,
   output logic       io_out_execute_stall,
   output logic       io_out_memory_stall,
   output logic       io_out_decode_flush,
   output logic       io_out_execute_flush,
   output logic       io_out_memory_flush,
   output logic       io_out_writeback_flush,
   output logic       io_out_mduDone,
   output logic       io_out_mduKill,
   output logic       io_out_dmemRespDrop,
   output logic [1:0] io_out_state
);

   localparam int unsigned CW = $clog2(MDU_LAT + 1);

   state_e        r_state, w_state_d;
   logic          r_mdu_pend, w_mdu_pend_d;
   logic          r_drop_pend, w_drop_pend_d;
   logic [CW-1:0] w_cnt;
   logic          w_cnt_load, w_cnt_dec, w_cnt_clear, w_cnt_done;
   logic          w_req_wait, w_ret_busy;

   assign w_req_wait  = io_in_dmemReqValid && !io_in_dmemRespValid;
   assign w_ret_busy  = r_mdu_pend && (w_cnt > CW'(1));
   assign w_cnt_clear = io_in_excpValid && (r_state != MEM_WAIT);
   assign w_cnt_load  = (r_state == RUN) && io_in_mduStart && !io_in_excpValid;
   // The MDU keeps running underneath a memory wait; only an exception outside MEM_WAIT stops it.
   assign w_cnt_dec   = (r_state == MEM_WAIT) ||
                        ((r_state == MDU_BUSY) && !io_in_excpValid);

   mdu_countdown #(
      .MDU_LAT (MDU_LAT)
   ) u_mdu_cnt (
      .clock   (clock),
      .reset   (reset),
      .i_load  (w_cnt_load),
      .i_dec   (w_cnt_dec),
      .i_clear (w_cnt_clear),
      .o_cnt   (w_cnt),
      .o_done  (w_cnt_done)
   );

   always_comb begin
      w_state_d     = r_state;
      w_mdu_pend_d  = r_mdu_pend;
      w_drop_pend_d = r_drop_pend;
      case (r_state)
         RUN: begin
            if (!io_in_excpValid) begin
               if (w_req_wait) begin
                  w_state_d    = MEM_WAIT;
                  w_mdu_pend_d = (w_cnt > CW'(1)) || w_cnt_load;
               end else if (w_cnt_load) begin
                  w_state_d = MDU_BUSY;
               end
            end
         end
         MDU_BUSY: begin
            if (io_in_excpValid) begin
               w_state_d = RUN;
            end else if (w_req_wait) begin
               w_state_d    = MEM_WAIT;
               w_mdu_pend_d = (w_cnt > CW'(1));
            end else if (w_cnt <= CW'(1)) begin
               w_state_d = RUN;
            end
         end
         MEM_WAIT: begin
            if (io_in_dmemRespValid) begin
               w_state_d     = w_ret_busy ? MDU_BUSY : RUN;
               w_mdu_pend_d  = 1'b0;
               w_drop_pend_d = 1'b0;
            end else if (io_in_excpValid) begin
               w_drop_pend_d = 1'b1;
            end
         end
         default: w_state_d = RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= RUN;
         r_mdu_pend  <= 1'b0;
         r_drop_pend <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_mdu_pend  <= w_mdu_pend_d;
         r_drop_pend <= w_drop_pend_d;
      end
   end

   // Outputs are gated by reset so random inputs during reset cannot leak stalls or flushes.
   always_comb begin
      io_out_fetch_stall     = 1'b0;
      io_out_decode_stall    = 1'b0;
      io_out_execute_stall   = 1'b0;
      io_out_memory_stall    = 1'b0;
      io_out_decode_flush    = 1'b0;
      io_out_execute_flush   = 1'b0;
      io_out_memory_flush    = 1'b0;
      io_out_writeback_flush = 1'b0;
      io_out_mduDone         = 1'b0;
      io_out_mduKill         = 1'b0;
      io_out_dmemRespDrop    = 1'b0;
      if (reset) begin
         io_out_mduDone = w_cnt_done;
         case (r_state)
            RUN: begin
               if (io_in_excpValid) begin
                  io_out_decode_flush  = 1'b1;
                  io_out_execute_flush = 1'b1;
                  io_out_memory_flush  = 1'b1;
                  io_out_mduKill       = (w_cnt != '0);
               end else if (io_in_brTaken) begin
                  io_out_decode_flush  = 1'b1;
                  io_out_execute_flush = 1'b1;
               end else if (io_in_loadUse) begin
                  io_out_fetch_stall   = 1'b1;
                  io_out_decode_stall  = 1'b1;
                  io_out_execute_flush = 1'b1;
               end
            end
            MDU_BUSY: begin
               if (io_in_excpValid) begin
                  io_out_decode_flush  = 1'b1;
                  io_out_execute_flush = 1'b1;
                  io_out_memory_flush  = 1'b1;
                  io_out_mduKill       = (w_cnt != '0);
               end else begin
                  io_out_fetch_stall   = 1'b1;
                  io_out_decode_stall  = 1'b1;
                  io_out_execute_stall = 1'b1;
                  io_out_memory_flush  = 1'b1;
               end
            end
            MEM_WAIT: begin
               io_out_fetch_stall     = !io_in_dmemRespValid;
               io_out_decode_stall    = !io_in_dmemRespValid;
               io_out_execute_stall   = !io_in_dmemRespValid || w_ret_busy;
               io_out_memory_stall    = !io_in_dmemRespValid;
               io_out_writeback_flush = !io_in_dmemRespValid;
               io_out_dmemRespDrop    = io_in_dmemRespValid && r_drop_pend;
               if (io_in_excpValid) begin
                  io_out_decode_flush  = 1'b1;
                  io_out_execute_flush = 1'b1;
                  io_out_memory_flush  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign io_out_state = r_state;

   a_mdu_start_in_run : assert property (@(posedge clock) disable iff (!reset)
      io_in_mduStart |-> (r_state == RUN));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus constrained-random traffic against a
// cycle-level reference model of the sequencing rules.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned LAT = 12;

   logic clock = 1'b0;
   logic reset;
   logic br, excp, lu, start, req, resp;
   logic fs, ds, es, ms, df, ef, mf, wf, done, kill, drop;
   logic [1:0]  st;
   logic [12:0] dut_vec;
   logic [12:0] obs;

   int errors = 0;
   int checks = 0;

   // Reference model: MDU cycles still owed, memory-wait flag, pending response drop.
   int   m_left;
   bit   m_mw;
   bit   m_dp;

   always #5 clock = ~clock;

   pipeline_hazard_ctrl #(
      .MDU_LAT (LAT)
   ) dut (
      .clock                  (clock),
      .reset                  (reset),
      .io_in_brTaken          (br),
      .io_in_excpValid        (excp),
      .io_in_loadUse          (lu),
      .io_in_mduStart         (start),
      .io_in_dmemReqValid     (req),
      .io_in_dmemRespValid    (resp),
      .io_out_fetch_stall     (fs),
      .io_out_decode_stall    (ds),
      .io_out_execute_stall   (es),
      .io_out_memory_stall    (ms),
      .io_out_decode_flush    (df),
      .io_out_execute_flush   (ef),
      .io_out_memory_flush    (mf),
      .io_out_writeback_flush (wf),
      .io_out_mduDone         (done),
      .io_out_mduKill         (kill),
      .io_out_dmemRespDrop    (drop),
      .io_out_state           (st)
   );

   assign dut_vec = {fs, ds, es, ms, df, ef, mf, wf, done, kill, drop, st};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   function automatic logic [12:0] model_out();
      logic o_fs, o_ds, o_es, o_ms, o_df, o_ef, o_mf, o_wf, o_dn, o_kl, o_dr;
      logic [1:0] o_st;
      {o_fs, o_ds, o_es, o_ms, o_df, o_ef, o_mf, o_wf, o_dn, o_kl, o_dr} = '0;
      o_st = 2'd0;
      if (!reset) return '0;
      if (m_mw) begin
         o_st = 2'd2;
         o_fs = !resp;
         o_ds = !resp;
         o_ms = !resp;
         o_wf = !resp;
         o_es = !resp || (m_left > 1);
         o_dn = (m_left == 1);
         o_dr = resp && m_dp;
         if (excp) {o_df, o_ef, o_mf} = 3'b111;
      end else if (m_left > 0) begin
         o_st = 2'd1;
         if (excp) begin
            {o_df, o_ef, o_mf} = 3'b111;
            o_kl = 1'b1;
         end else begin
            {o_fs, o_ds, o_es, o_mf} = 4'b1111;
            o_dn = (m_left == 1);
         end
      end else begin
         if (excp) {o_df, o_ef, o_mf} = 3'b111;
         else if (br) {o_df, o_ef} = 2'b11;
         else if (lu) {o_fs, o_ds, o_ef} = 3'b111;
      end
      return {o_fs, o_ds, o_es, o_ms, o_df, o_ef, o_mf, o_wf, o_dn, o_kl, o_dr, o_st};
   endfunction

   task automatic model_step();
      if (!reset) begin
         m_left = 0;
         m_mw   = 1'b0;
         m_dp   = 1'b0;
      end else if (m_mw) begin
         if (m_left > 0) m_left--;
         if (resp) begin
            m_mw = 1'b0;
            m_dp = 1'b0;
         end else if (excp) begin
            m_dp = 1'b1;
         end
      end else if (m_left > 0) begin
         if (excp) m_left = 0;
         else begin
            m_left--;
            if (req && !resp) m_mw = 1'b1;
         end
      end else if (!excp) begin
         if (req && !resp) m_mw = 1'b1;
         else if (start) m_left = LAT - 1;
      end
   endtask

   task automatic idle_in();
      {br, excp, lu, start, req, resp} = '0;
   endtask

   // Inputs are already applied; sample on the falling edge, advance the model on the rising one.
   task automatic cycle();
      @(negedge clock);
      obs = dut_vec;
      check("cycle_outputs", obs, model_out());
      @(posedge clock);
      model_step();
      #1;
   endtask

   initial begin
      int ns, nw, nd, nk, nb, at;
      m_left = 0;
      m_mw   = 1'b0;
      m_dp   = 1'b0;
      reset  = 1'b0;
      idle_in();

      // Reset held with random inputs: everything must read zero.
      repeat (3) begin
         {br, excp, lu, start, req, resp} = 6'($urandom);
         cycle();
      end
      check("reset_all_zero", obs, 13'd0);
      @(negedge clock);
      idle_in();
      reset = 1'b1;
      @(posedge clock);
      #1;
      cycle();
      check("release_run", obs[1:0], 2'd0);

      // Load-use then branch+load-use.
      lu = 1'b1;
      cycle();
      check("loaduse_vec", obs, 13'b1_1000_1000_0000);
      lu = 1'b0;
      cycle();
      check("loaduse_one_cycle", obs, 13'd0);
      br = 1'b1;
      lu = 1'b1;
      cycle();
      check("branch_wins", obs, 13'b0_0001_1000_0000);
      idle_in();
      cycle();

      // Full MDU op.
      start = 1'b1;
      cycle();
      check("mdu_launch_no_stall", obs[12], 1'b0);
      start = 1'b0;
      ns = 0;
      nd = 0;
      repeat (LAT + 2) begin
         cycle();
         ns += int'(obs[12]);
         nd += int'(obs[4]);
      end
      check("mdu_stall_cycles", ns, LAT - 1);
      check("mdu_done_pulses", nd, 1);
      check("mdu_back_run", obs[1:0], 2'd0);

      // Exception kills an in-flight MDU op.
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      cycle();
      excp = 1'b1;
      cycle();
      check("excp_kill", obs[3], 1'b1);
      check("excp_flush3", obs[8:6], 3'b111);
      excp = 1'b0;
      nd = 0;
      nk = 0;
      cycle();
      check("excp_to_run", obs[1:0], 2'd0);
      repeat (LAT) begin
         cycle();
         nd += int'(obs[4]);
         nk += int'(obs[3]);
      end
      check("killed_no_done", nd + nk, 0);

      // Memory wait with response five cycles after the request.
      req = 1'b1;
      cycle();
      req = 1'b0;
      ns = 0;
      nw = 0;
      repeat (4) begin
         cycle();
         ns += int'(obs[12]);
         nw += int'(obs[5]);
      end
      resp = 1'b1;
      cycle();
      check("resp_cycle_no_stall", obs[12], 1'b0);
      resp = 1'b0;
      check("wait_stall_cycles", ns, 4);
      check("wait_wb_flush_cycles", nw, 4);

      // Exception during the wait marks the response for discard.
      req = 1'b1;
      cycle();
      req = 1'b0;
      excp = 1'b1;
      cycle();
      excp = 1'b0;
      cycle();
      resp = 1'b1;
      cycle();
      check("resp_drop", obs[2], 1'b1);
      resp = 1'b0;
      cycle();

      // MDU at cnt=10 meets a memory wait and resumes with cnt=7.
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      req = 1'b1;
      cycle();
      req = 1'b0;
      cycle();
      resp = 1'b1;
      cycle();
      resp = 1'b0;
      nb = 0;
      at = -1;
      for (int k = 0; k < 7; k++) begin
         cycle();
         nb += int'(obs[1:0] == 2'd1);
         if (obs[4]) at = k;
      end
      check("resume_busy_cycles", nb, 7);
      check("resume_done_slot", at, 6);
      cycle();
      check("resume_end_run", obs[1:0], 2'd0);

      // MDU finishes inside the memory wait.
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (8) cycle();
      req = 1'b1;
      cycle();
      req = 1'b0;
      nd = 0;
      repeat (3) begin
         cycle();
         nd += int'(obs[4] && (obs[1:0] == 2'd2));
      end
      resp = 1'b1;
      cycle();
      resp = 1'b0;
      cycle();
      check("done_in_wait", nd, 1);
      check("wait_end_run", obs[1:0], 2'd0);

      // Asynchronous reset in the middle of an MDU op.
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      lu   = 1'b1;
      excp = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_zero", dut_vec, 13'd0);
      cycle();
      idle_in();
      reset = 1'b1;
      cycle();
      check("after_async_reset", obs[1:0], 2'd0);

      // Constrained-random traffic.
      for (int i = 0; i < 600; i++) begin
         br    = ($urandom_range(0, 3) == 0);
         lu    = ($urandom_range(0, 3) == 0);
         excp  = ($urandom_range(0, 9) == 0);
         req   = ($urandom_range(0, 5) == 0);
         resp  = ($urandom_range(0, 2) == 0);
         start = 1'b0;
         if (!m_mw && (m_left == 0) && ($urandom_range(0, 5) == 0)) begin
            {br, lu, excp, req} = '0;
            start = 1'b1;
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
